// File: rtl/load_return.sv
// Load/store issue to data memory and in-order load return to the register-file writeback port.
// Optional feature: define STORE_FWD_EN to forward recent store data to dependent loads.
module load_return #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en_i,
    input  logic              st_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [DATA_W-1:0] dm_wdata_o,
    output logic              dm_we_o,
    input  logic [DATA_W-1:0] dm_rdata_i,
    output logic              wb_valid_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [2:0]        ld_pend_o,
    output logic              req_err_o
);
    localparam int DEPTH = RD_LAT + 1;

    logic ld_acc;
    logic issue;
    assign ld_acc = ld_en_i & ~st_en_i;   // a colliding store takes the port
    assign issue  = ld_en_i | st_en_i;

    logic [ADDR_W-1:0] dm_addr_reg;
    logic [DATA_W-1:0] dm_wdata_reg;
    logic              dm_we_reg;
    logic              req_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            dm_addr_reg  <= '0;
            dm_wdata_reg <= '0;
            dm_we_reg    <= 1'b0;
            req_err_reg  <= 1'b0;
        end else begin
            if (issue)
                dm_addr_reg <= addr_i;
            if (st_en_i)
                dm_wdata_reg <= wdata_i;
            dm_we_reg   <= st_en_i;
            req_err_reg <= ld_en_i & st_en_i;
        end
    end

    logic [DEPTH-1:0]           tag_valid_reg;
    logic [DEPTH-1:0][RD_W-1:0] tag_rd_reg;
    logic [DATA_W-1:0]          ld_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_reg <= '0;
            tag_rd_reg    <= '0;
        end else begin
            tag_valid_reg[0] <= ld_acc;
            tag_rd_reg[0]    <= rd_i;
            for (int i = 1; i < DEPTH; i++) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_rd_reg[i]    <= tag_rd_reg[i-1];
            end
        end
    end

`ifdef STORE_FWD_EN
    logic [RD_LAT-1:0]             hist_valid_reg;
    logic [RD_LAT-1:0][ADDR_W-1:0] hist_addr_reg;
    logic [RD_LAT-1:0][DATA_W-1:0] hist_data_reg;
    logic [DEPTH-1:0]              tag_fwd_reg;
    logic [DEPTH-1:0][DATA_W-1:0]  tag_fdata_reg;
    logic [DEPTH-1:0]              fwd_match;
    logic [DEPTH-1:0][DATA_W-1:0]  cand_data;
    logic                          fwd_hit;
    logic [DATA_W-1:0]             fwd_data;

    // Candidate 0 is the store currently on the memory port; higher indices are older.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cand
            if (gi == 0) begin : g_live
                assign fwd_match[gi] = dm_we_reg && (dm_addr_reg == addr_i);
                assign cand_data[gi] = dm_wdata_reg;
            end else begin : g_hist
                assign fwd_match[gi] = hist_valid_reg[gi-1] && (hist_addr_reg[gi-1] == addr_i);
                assign cand_data[gi] = hist_data_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (fwd_match[i]) begin
                fwd_hit  = 1'b1;
                fwd_data = cand_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_valid_reg <= '0;
            hist_addr_reg  <= '0;
            hist_data_reg  <= '0;
            tag_fwd_reg    <= '0;
            tag_fdata_reg  <= '0;
        end else begin
            hist_valid_reg[0] <= dm_we_reg;
            hist_addr_reg[0]  <= dm_addr_reg;
            hist_data_reg[0]  <= dm_wdata_reg;
            for (int i = 1; i < RD_LAT; i++) begin
                hist_valid_reg[i] <= hist_valid_reg[i-1];
                hist_addr_reg[i]  <= hist_addr_reg[i-1];
                hist_data_reg[i]  <= hist_data_reg[i-1];
            end
            tag_fwd_reg[0]   <= fwd_hit;
            tag_fdata_reg[0] <= fwd_data;
            for (int i = 1; i < DEPTH; i++) begin
                tag_fwd_reg[i]   <= tag_fwd_reg[i-1];
                tag_fdata_reg[i] <= tag_fdata_reg[i-1];
            end
        end
    end

    assign ld_data = tag_fwd_reg[RD_LAT] ? tag_fdata_reg[RD_LAT] : dm_rdata_i;
`else
    assign ld_data = dm_rdata_i;
`endif

    logic              wb_valid_reg;
    logic [RD_W-1:0]   wb_rd_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic [2:0]        ld_pend_reg;
    logic              ret;
    assign ret = tag_valid_reg[RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
            ld_pend_reg  <= '0;
        end else begin
            wb_valid_reg <= ret;
            if (ret) begin
                wb_rd_reg   <= tag_rd_reg[RD_LAT];
                wb_data_reg <= ld_data;
            end
            // Counts tags in the pipe, so it tops out at the pipe depth.
            case ({ld_acc, ret})
                2'b10:   ld_pend_reg <= ld_pend_reg + 3'd1;
                2'b01:   ld_pend_reg <= ld_pend_reg - 3'd1;
                default: ld_pend_reg <= ld_pend_reg;
            endcase
        end
    end

    assign dm_addr_o  = dm_addr_reg;
    assign dm_wdata_o = dm_wdata_reg;
    assign dm_we_o    = dm_we_reg;
    assign req_err_o  = req_err_reg;
    assign wb_valid_o = wb_valid_reg;
    assign wb_rd_o    = wb_rd_reg;
    assign wb_data_o  = wb_data_reg;
    assign ld_pend_o  = ld_pend_reg;
endmodule

// File: tb/tb_load_return.sv
// Directed bench for load_return with a read-only memory model and a writeback scoreboard.
module tb_load_return;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_en_i, st_en_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [RD_W-1:0]   rd_i;
    logic [ADDR_W-1:0] dm_addr_o;
    logic [DATA_W-1:0] dm_wdata_o;
    logic              dm_we_o;
    logic [DATA_W-1:0] dm_rdata_i;
    logic              wb_valid_o;
    logic [RD_W-1:0]   wb_rd_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [2:0]        ld_pend_o;
    logic              req_err_o;

    load_return #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_W(RD_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .ld_en_i(ld_en_i), .st_en_i(st_en_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rd_i(rd_i), .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
        .dm_we_o(dm_we_o), .dm_rdata_i(dm_rdata_i), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .ld_pend_o(ld_pend_o), .req_err_o(req_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents are fixed (writes ignored), so forwarded data is distinguishable.
    function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
        if (a == 10'h010) return 32'hDEADBEEF;
        if (a == 10'h030) return 32'h0000_1111;
        return {16'hA5A5, 6'b0, a};
    endfunction

    logic [RD_LAT-1:0][ADDR_W-1:0] apipe = '0;
    always @(posedge clk) apipe <= {apipe[RD_LAT-2:0], dm_addr_o};
    assign dm_rdata_i = mem_f(apipe[RD_LAT-1]);

    int checks = 0;
    int errors = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;
    exp_t exp_q[$];
    int   pend_max = 0;

    always @(negedge clk) begin
        exp_t e;
        if (wb_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb", wb_valid_o, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd", wb_rd_o, e.rd);
                chk("wb_data", wb_data_o, e.data);
                chk("wb_cycle", cyc, e.due);
                $display("WB rd=%0d data=%08h cycle=%0d", wb_rd_o, wb_data_o, cyc);
            end
        end
        if (ld_pend_o > pend_max) pend_max = int'(ld_pend_o);
    end

    task automatic step(input logic ld, input logic st, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input logic [RD_W-1:0] rd,
                        input logic [DATA_W-1:0] exp_data);
        exp_t e;
        ld_en_i = ld; st_en_i = st; addr_i = a; wdata_i = wd; rd_i = rd;
        if (ld && !st && !rst) begin
            e.rd = rd; e.data = exp_data; e.due = cyc + RD_LAT + 2;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        ld_en_i = 1'b0; st_en_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    logic [DATA_W-1:0] fwd_cafe, fwd_beef, fwd_young;
    initial begin
`ifdef STORE_FWD_EN
        fwd_cafe = 32'h0000_CAFE; fwd_beef = 32'h0000_BEEF; fwd_young = 32'h0000_5678;
`else
        fwd_cafe = 32'h0000_1111; fwd_beef = 32'h0000_1111; fwd_young = 32'h0000_1111;
`endif
        // Reset with a load request held high
        rst = 1'b1; ld_en_i = 1'b1; st_en_i = 1'b0; addr_i = 10'h3FF; wdata_i = 32'hFFFF_FFFF; rd_i = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dm_addr", dm_addr_o, 0);
        chk("rst_dm_wdata", dm_wdata_o, 0);
        chk("rst_dm_we", dm_we_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_wb_rd", wb_rd_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_ld_pend", ld_pend_o, 0);
        chk("rst_req_err", req_err_o, 0);
        ld_en_i = 1'b0; rst = 1'b0;
        idle(1);

        // Single load
        step(1'b1, 1'b0, 10'h010, '0, 5'd7, 32'hDEADBEEF);
        chk("single_dm_addr", dm_addr_o, 10'h010);
        chk("single_dm_we", dm_we_o, 0);
        chk("single_pend", ld_pend_o, 1);
        idle(5);
        chk("single_pend_done", ld_pend_o, 0);

        // Back-to-back loads
        pend_max = 0;
        for (int i = 1; i <= 4; i++)
            step(1'b1, 1'b0, 10'(i), '0, 5'(i), mem_f(10'(i)));
        idle(6);
        chk("b2b_pend_peak", pend_max, 3);
        chk("b2b_pend_done", ld_pend_o, 0);
        chk("b2b_drained", exp_q.size(), 0);

        // Load/store conflict: store wins, load dropped
        step(1'b1, 1'b1, 10'h020, 32'h55, 5'd3, '0);
        chk("conf_we", dm_we_o, 1);
        chk("conf_err", req_err_o, 1);
        chk("conf_addr", dm_addr_o, 10'h020);
        chk("conf_wdata", dm_wdata_o, 32'h55);
        chk("conf_pend", ld_pend_o, 0);
        idle(1);
        chk("conf_err_pulse", req_err_o, 0);
        chk("conf_we_clr", dm_we_o, 0);
        chk("conf_addr_hold", dm_addr_o, 10'h020);
        idle(5);

        // Reset while a load is in flight
        step(1'b1, 1'b0, 10'h005, '0, 5'd12, mem_f(10'h005));
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_pend", ld_pend_o, 0);
        chk("midrst_valid", wb_valid_o, 0);
        idle(5);
        chk("midrst_pend_after", ld_pend_o, 0);

        // Store then dependent load on the next cycle
        step(1'b0, 1'b1, 10'h030, 32'h0000_CAFE, '0, '0);
        step(1'b1, 1'b0, 10'h030, '0, 5'd9, fwd_cafe);
        idle(5);
        // Dependent load two cycles after the store
        step(1'b0, 1'b1, 10'h030, 32'h0000_BEEF, '0, '0);
        idle(1);
        step(1'b1, 1'b0, 10'h030, '0, 5'd10, fwd_beef);
        idle(5);
        // Two stores to one address: the younger one supplies the data
        step(1'b0, 1'b1, 10'h030, 32'h0000_1234, '0, '0);
        step(1'b0, 1'b1, 10'h030, 32'h0000_5678, '0, '0);
        step(1'b1, 1'b0, 10'h030, '0, 5'd11, fwd_young);
        // Store to a different address does not affect the load
        step(1'b0, 1'b1, 10'h032, 32'h0000_9999, '0, '0);
        step(1'b1, 1'b0, 10'h031, '0, 5'd13, mem_f(10'h031));
        idle(6);
        chk("final_drained", exp_q.size(), 0);
        chk("final_pend", ld_pend_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
